// File: rtl/button_dir_debounce_if.sv
// Tick/button/direction bundle between the stimulus side (master) and the
// debounce + direction arbiter (slave).
interface button_dir_debounce_if;
  logic       tick;
  logic [3:0] btn_raw;
  logic [3:0] press;
  logic [1:0] dir_out;
  logic       dir_valid;
  logic       dir_ack;

  modport master (
    output tick, btn_raw, dir_ack,
    input  press, dir_out, dir_valid
  );

  modport slave (
    input  tick, btn_raw, dir_ack,
    output press, dir_out, dir_valid
  );
endinterface

// File: rtl/button_dir_debounce.sv
// Synchronises and tick-debounces four direction buttons, pulses a press per
// button, and arbitrates presses into a snake direction with valid/ack.
module button_dir_debounce #(
  parameter int unsigned DB_TICKS = 20,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  button_dir_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_TICKS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_stable;
  logic [3:0]       r_stable_q;
  logic [3:0]       r_press;
  logic [CNT_W-1:0] r_cnt [4];
  logic [1:0]       r_dir_out;
  state_t           r_state;

  logic [3:0]       w_btn_s;
  logic [3:0]       w_ok;
  logic             w_accept;
  logic [1:0]       w_cand;
  state_t           w_state_nxt;
  logic             w_dir_valid;

  assign w_btn_s = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any tick on which the synchronised level agrees with stable restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (bus.tick) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_btn_s[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_stable[i] <= w_btn_s[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_q <= '0;
      r_press    <= '0;
    end else begin
      r_stable_q <= r_stable;
      r_press    <= r_stable & ~r_stable_q;
    end
  end

  // Only the two directions perpendicular to the current one are eligible.
  always_comb begin
    w_ok = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      w_ok[d] = r_press[d] && (2'(d) != r_dir_out) && (2'(d) != (r_dir_out ^ 2'b10));
    end
  end

  always_comb begin
    w_accept = |w_ok;
    w_cand   = 2'd3;
    if (w_ok[0]) begin
      w_cand = 2'd0;
    end else if (w_ok[1]) begin
      w_cand = 2'd1;
    end else if (w_ok[2]) begin
      w_cand = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir_out <= 2'd1;
    end else if (w_accept) begin
      r_dir_out <= w_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fresh accept always wins over an ack in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_PEND;
      ST_PEND: if (!w_accept && bus.dir_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dir_valid = (r_state == ST_PEND);
  end

  assign bus.press     = r_press;
  assign bus.dir_out   = r_dir_out;
  assign bus.dir_valid = w_dir_valid;

endmodule
